// File: rtl/apb_2slv_master_ctrl_pkg.sv
// Shared types and default sizes for the two-slave APB3 master controller.
//   apb_state_e : bus phase of the master (IDLE, SETUP, ACCESS)
//   apb_slv_e   : slave selected by the address MSB (SLV1 when 0, SLV2 when 1)
package apb_2slv_master_ctrl_pkg;

    localparam int unsigned DEFAULT_AW        = 9;
    localparam int unsigned DEFAULT_DW        = 8;
    localparam int unsigned DEFAULT_TO_CYCLES = 16;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } apb_state_e;

    typedef enum logic {
        SLV1,
        SLV2
    } apb_slv_e;

endpackage

// File: rtl/apb_2slv_master_ctrl.sv
// APB3 master controller for a two-slave APB subsystem.
// Takes requests from the user side and sequences them onto the bus as
// IDLE -> SETUP -> ACCESS. The address MSB picks slave 1 (0) or slave 2 (1).
// A request arriving at ACCESS completion chains straight into the next SETUP.
//
// Optional feature: define APB_TIMEOUT_EN to abort an ACCESS phase after
// TO_CYCLES stalled cycles (o_done with o_slverr=1). Without it the master
// waits for i_pready indefinitely.
//
// Ports
//   pclk, presetn          : clock, asynchronous active-low reset
//   i_ptransfer            : request valid (sampled in IDLE and at ACCESS completion)
//   i_pwrite               : request direction, 1 = write
//   i_pwaddr / i_praddr    : write / read address
//   i_pwdata               : write data
//   o_prdata               : last good read data (registered)
//   o_done, o_slverr       : one-cycle completion pulse and its error flag
//   o_psel1, o_psel2       : APB selects
//   o_penable, o_pwrite    : APB enable and direction
//   o_paddr, o_pwdata      : APB address and write data
//   i_pready, i_pslverr    : response from the selected slave
//   i_prdata1, i_prdata2   : read data from slave 1 / slave 2
module apb_2slv_master_ctrl
    import apb_2slv_master_ctrl_pkg::*;
#(
    parameter int unsigned AW        = DEFAULT_AW,
    parameter int unsigned DW        = DEFAULT_DW,
    parameter int unsigned TO_CYCLES = DEFAULT_TO_CYCLES
) (
    input  logic          pclk,
    input  logic          presetn,
    input  logic          i_ptransfer,
    input  logic          i_pwrite,
    input  logic [AW-1:0] i_pwaddr,
    input  logic [DW-1:0] i_pwdata,
    input  logic [AW-1:0] i_praddr,
    output logic [DW-1:0] o_prdata,
    output logic          o_done,
    output logic          o_slverr,
    output logic          o_psel1,
    output logic          o_psel2,
    output logic          o_penable,
    output logic          o_pwrite,
    output logic [AW-1:0] o_paddr,
    output logic [DW-1:0] o_pwdata,
    input  logic          i_pready,
    input  logic [DW-1:0] i_prdata1,
    input  logic [DW-1:0] i_prdata2,
    input  logic          i_pslverr
);

    apb_state_e    state_q;
    apb_slv_e      slv_q;
    logic [AW-1:0] addr_q;
    logic          write_q;
    logic [DW-1:0] wdata_q;
    logic [DW-1:0] prdata_q;
    logic          psel1_q;
    logic          psel2_q;
    logic          penable_q;
    logic          done_q;
    logic          slverr_q;

    logic [AW-1:0] cap_addr;
    apb_slv_e      cap_slv;
    logic          start;
    logic          to_hit;

    always_comb begin
        cap_addr = i_pwrite ? i_pwaddr : i_praddr;
        cap_slv  = cap_addr[AW-1] ? SLV2 : SLV1;
        // A new request is taken in IDLE or on the completing ACCESS cycle.
        start    = i_ptransfer &
                   ((state_q == IDLE) | ((state_q == ACCESS) & i_pready));
    end

`ifdef APB_TIMEOUT_EN
    localparam int unsigned ToW = $clog2(TO_CYCLES + 1);

    logic [ToW-1:0] to_cnt_q;

    // Fires on the TO_CYCLES-th stalled ACCESS cycle.
    assign to_hit = (state_q == ACCESS) && !i_pready &&
                    (to_cnt_q == ToW'(TO_CYCLES - 1));

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            to_cnt_q <= '0;
        end else if (start) begin
            to_cnt_q <= '0;
        end else if ((state_q == ACCESS) && !i_pready) begin
            to_cnt_q <= to_cnt_q + 1'b1;
        end
    end
`else
    logic unused_to_cycles;
    assign unused_to_cycles = ^TO_CYCLES;
    assign to_hit           = 1'b0;
`endif

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q   <= IDLE;
            slv_q     <= SLV1;
            addr_q    <= '0;
            write_q   <= 1'b0;
            wdata_q   <= '0;
            prdata_q  <= '0;
            psel1_q   <= 1'b0;
            psel2_q   <= 1'b0;
            penable_q <= 1'b0;
            done_q    <= 1'b0;
            slverr_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                end
                SETUP: begin
                    state_q   <= ACCESS;
                    penable_q <= 1'b1;
                end
                ACCESS: begin
                    if (i_pready) begin
                        done_q   <= 1'b1;
                        slverr_q <= i_pslverr;
                        // Failed reads leave the previous good data in place.
                        if (!write_q && !i_pslverr) begin
                            prdata_q <= (slv_q == SLV2) ? i_prdata2 : i_prdata1;
                        end
                        state_q   <= IDLE;
                        psel1_q   <= 1'b0;
                        psel2_q   <= 1'b0;
                        penable_q <= 1'b0;
                    end else if (to_hit) begin
                        done_q    <= 1'b1;
                        slverr_q  <= 1'b1;
                        state_q   <= IDLE;
                        psel1_q   <= 1'b0;
                        psel2_q   <= 1'b0;
                        penable_q <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase

            // Capture overrides the IDLE return above, so a chained request
            // keeps psel high when it targets the same slave.
            if (start) begin
                state_q   <= SETUP;
                slv_q     <= cap_slv;
                addr_q    <= cap_addr;
                write_q   <= i_pwrite;
                wdata_q   <= i_pwdata;
                psel1_q   <= (cap_slv == SLV1);
                psel2_q   <= (cap_slv == SLV2);
                penable_q <= 1'b0;
            end
        end
    end

    assign o_prdata  = prdata_q;
    assign o_done    = done_q;
    assign o_slverr  = slverr_q;
    assign o_psel1   = psel1_q;
    assign o_psel2   = psel2_q;
    assign o_penable = penable_q;
    assign o_pwrite  = write_q;
    assign o_paddr   = addr_q;
    assign o_pwdata  = wdata_q;

endmodule

// File: tb/tb_apb_2slv_master_ctrl.sv
// Self-checking bench for apb_2slv_master_ctrl (AW=9, DW=8, TO_CYCLES=16).
// A transaction-level model predicts every output each cycle; directed
// scenarios add literal expectations at key points.
module tb_apb_2slv_master_ctrl;

`ifdef APB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic       pclk;
    logic       presetn;
    logic       i_ptransfer;
    logic       i_pwrite;
    logic [8:0] i_pwaddr;
    logic [7:0] i_pwdata;
    logic [8:0] i_praddr;
    logic [7:0] o_prdata;
    logic       o_done;
    logic       o_slverr;
    logic       o_psel1;
    logic       o_psel2;
    logic       o_penable;
    logic       o_pwrite;
    logic [8:0] o_paddr;
    logic [7:0] o_pwdata;
    logic       i_pready;
    logic [7:0] i_prdata1;
    logic [7:0] i_prdata2;
    logic       i_pslverr;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    apb_2slv_master_ctrl #(
        .AW       (9),
        .DW       (8),
        .TO_CYCLES(16)
    ) dut (
        .pclk       (pclk),
        .presetn    (presetn),
        .i_ptransfer(i_ptransfer),
        .i_pwrite   (i_pwrite),
        .i_pwaddr   (i_pwaddr),
        .i_pwdata   (i_pwdata),
        .i_praddr   (i_praddr),
        .o_prdata   (o_prdata),
        .o_done     (o_done),
        .o_slverr   (o_slverr),
        .o_psel1    (o_psel1),
        .o_psel2    (o_psel2),
        .o_penable  (o_penable),
        .o_pwrite   (o_pwrite),
        .o_paddr    (o_paddr),
        .o_pwdata   (o_pwdata),
        .i_pready   (i_pready),
        .i_prdata1  (i_prdata1),
        .i_prdata2  (i_prdata2),
        .i_pslverr  (i_pslverr)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction model: phase 0 = no transfer, 1 = address phase, 2 = data phase.
    int         phase;
    int         waits;
    logic [8:0] req_addr;
    logic       req_wr;
    logic [7:0] req_data;
    logic [7:0] m_prdata;
    logic       m_done;
    logic       m_err;

    always @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            phase    <= 0;
            waits    <= 0;
            req_addr <= '0;
            req_wr   <= 1'b0;
            req_data <= '0;
            m_prdata <= '0;
            m_done   <= 1'b0;
            m_err    <= 1'b0;
        end else begin
            m_done <= 1'b0;
            if (phase == 0) begin
                if (i_ptransfer) begin
                    req_addr <= i_pwrite ? i_pwaddr : i_praddr;
                    req_wr   <= i_pwrite;
                    req_data <= i_pwdata;
                    phase    <= 1;
                end
            end else if (phase == 1) begin
                phase <= 2;
                waits <= 0;
            end else if (i_pready) begin
                m_done <= 1'b1;
                m_err  <= i_pslverr;
                if (!req_wr && !i_pslverr) m_prdata <= req_addr[8] ? i_prdata2 : i_prdata1;
                if (i_ptransfer) begin
                    req_addr <= i_pwrite ? i_pwaddr : i_praddr;
                    req_wr   <= i_pwrite;
                    req_data <= i_pwdata;
                    phase    <= 1;
                end else begin
                    phase <= 0;
                end
            end else if (TO_EN && (waits + 1 == 16)) begin
                m_done <= 1'b1;
                m_err  <= 1'b1;
                phase  <= 0;
            end else begin
                waits <= waits + 1;
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge pclk) begin
        if (chk_en && presetn) begin
            check("psel1",   o_psel1,   (phase != 0) && !req_addr[8]);
            check("psel2",   o_psel2,   (phase != 0) && req_addr[8]);
            check("penable", o_penable, phase == 2);
            check("pwrite",  o_pwrite,  req_wr);
            check("paddr",   o_paddr,   req_addr);
            check("pwdata",  o_pwdata,  req_data);
            check("prdata",  o_prdata,  m_prdata);
            check("done",    o_done,    m_done);
            if (m_done) check("slverr", o_slverr, m_err);
        end
    end

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    int pen_cnt;
    int idle_cnt;
    int done_cnt;
    bit got_done;

    initial begin
        presetn     = 1'b0;
        i_ptransfer = 1'b0;
        i_pwrite    = 1'b0;
        i_pwaddr    = '0;
        i_pwdata    = '0;
        i_praddr    = '0;
        i_pready    = 1'b0;
        i_prdata1   = '0;
        i_prdata2   = '0;
        i_pslverr   = 1'b0;
        #3;
        check("reset_outputs",
              {o_prdata, o_done, o_slverr, o_psel1, o_psel2, o_penable, o_pwrite, o_paddr,
               o_pwdata}, 32'h0);
        tick();
        tick();
        presetn = 1'b1;
        chk_en  = 1'b1;
        tick();

        // 1: zero-wait write 0x0A5 <- 0x3C to slave 1.
        i_ptransfer = 1'b1;
        i_pwrite    = 1'b1;
        i_pwaddr    = 9'h0A5;
        i_pwdata    = 8'h3C;
        i_pready    = 1'b1;
        tick();
        check("t1_setup_psel", {o_psel1, o_psel2, o_penable}, 3'b100);
        check("t1_setup_addr", o_paddr, 9'h0A5);
        check("t1_setup_data", o_pwdata, 8'h3C);
        i_ptransfer = 1'b0;
        tick();
        check("t1_access", {o_psel1, o_psel2, o_penable}, 3'b101);
        tick();
        check("t1_done", {o_done, o_slverr, o_psel1, o_penable}, 4'b1000);
        tick();
        check("t1_done_pulse", o_done, 1'b0);

        // 2: read 0x1F0 from slave 2 with three wait states.
        i_ptransfer = 1'b1;
        i_pwrite    = 1'b0;
        i_praddr    = 9'h1F0;
        i_prdata1   = 8'hEE;
        i_prdata2   = 8'h5A;
        i_pready    = 1'b0;
        tick();
        check("t2_setup_psel", {o_psel1, o_psel2, o_penable}, 3'b010);
        i_ptransfer = 1'b0;
        pen_cnt     = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            pen_cnt += int'(o_penable);
        end
        check("t2_prdata_before", o_prdata, 8'h00);
        i_pready = 1'b1;
        tick();
        check("t2_penable_cycles", pen_cnt, 4);
        check("t2_done", {o_done, o_slverr}, 2'b10);
        check("t2_prdata", o_prdata, 8'h5A);
        i_pready = 1'b0;
        tick();

        // 3: back-to-back write 0x010 then read 0x110, request held.
        i_ptransfer = 1'b1;
        i_pwrite    = 1'b1;
        i_pwaddr    = 9'h010;
        i_pwdata    = 8'h77;
        i_prdata2   = 8'h99;
        i_pready    = 1'b1;
        idle_cnt    = 0;
        done_cnt    = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (i < 4 && !(o_psel1 || o_psel2)) idle_cnt++;
            done_cnt += int'(o_done);
            if (i == 0) begin
                check("t3_first_psel1", o_psel1, 1'b1);
                i_pwrite = 1'b0;
                i_praddr = 9'h110;
            end
            if (i == 2) begin
                check("t3_second_psel2", {o_psel1, o_psel2}, 2'b01);
                i_ptransfer = 1'b0;
            end
        end
        check("t3_idle_cycles", idle_cnt, 0);
        check("t3_done_pulses", done_cnt, 2);
        check("t3_prdata", o_prdata, 8'h99);

        // 4: read with slave error keeps the previous read data.
        i_ptransfer = 1'b1;
        i_pwrite    = 1'b0;
        i_praddr    = 9'h050;
        i_prdata1   = 8'h11;
        i_pslverr   = 1'b1;
        tick();
        i_ptransfer = 1'b0;
        tick();
        tick();
        check("t4_err", {o_done, o_slverr}, 2'b11);
        check("t4_prdata_kept", o_prdata, 8'h99);
        i_pslverr = 1'b0;
        tick();

        // 5: reset asserted during ACCESS.
        i_ptransfer = 1'b1;
        i_pwrite    = 1'b1;
        i_pwaddr    = 9'h1AA;
        i_pwdata    = 8'hC3;
        i_pready    = 1'b0;
        tick();
        i_ptransfer = 1'b0;
        tick();
        check("t5_in_access", {o_psel2, o_penable}, 2'b11);
        #2;
        presetn = 1'b0;
        #1;
        check("t5_reset_outputs",
              {o_prdata, o_done, o_slverr, o_psel1, o_psel2, o_penable, o_pwrite, o_paddr,
               o_pwdata}, 32'h0);
        tick();
        presetn  = 1'b1;
        done_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            done_cnt += int'(o_done | o_psel1 | o_psel2);
        end
        check("t5_no_done_after_reset", done_cnt, 0);

        // 6: slave never ready.
        i_ptransfer = 1'b1;
        i_pwrite    = 1'b0;
        i_praddr    = 9'h020;
        i_pready    = 1'b0;
        tick();
        i_ptransfer = 1'b0;
        pen_cnt     = 0;
        got_done    = 1'b0;
`ifdef APB_TIMEOUT_EN
        for (int i = 0; i < 40 && !got_done; i++) begin
            tick();
            if (o_done) begin
                got_done = 1'b1;
                check("t6_abort_flags", {o_slverr, o_psel1, o_penable}, 3'b100);
            end else begin
                pen_cnt += int'(o_penable);
            end
        end
        check("t6_abort_seen", got_done, 1'b1);
        check("t6_access_cycles", pen_cnt, 16);
        check("t6_prdata_kept", o_prdata, 8'h00);
`else
        done_cnt = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            done_cnt += int'(o_done);
        end
        check("t6_still_access", {o_psel1, o_penable}, 2'b11);
        check("t6_no_done", done_cnt, 0);
        i_pready = 1'b1;
        tick();
        i_pready = 1'b0;
`endif
        tick();
        tick();

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
